// File: rtl/melody_seq.sv
// melody_seq: key-toggled melody player driven from a run-time writable note table.
// Optional articulation gap between notes: define MELODY_SEQ_ARTIC_GAP_EN.
module melody_seq #(
    parameter int unsigned NUM_NOTES  = 16,
    parameter int unsigned PERIOD_W   = 20,
    parameter int unsigned DUR_W      = 4,
    parameter int unsigned BEAT_CLKS  = 6_250_000,
    parameter logic        IDLE_LEVEL = 1'b1,
    parameter int unsigned IDX_W      = $clog2(NUM_NOTES)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                key,
    input  logic                loop_en,
    input  logic                tbl_we,
    input  logic [IDX_W-1:0]    tbl_addr,
    input  logic [PERIOD_W-1:0] tbl_period,
    input  logic [DUR_W-1:0]    tbl_dur,
    output logic                buzzer_o,
    output logic                playing_o,
    output logic [IDX_W-1:0]    note_idx_o,
    output logic [3:0]          led_o,
    output logic                done_o
);

    localparam int unsigned       BEAT_W    = (BEAT_CLKS > 1) ? $clog2(BEAT_CLKS) : 1;
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEAT_CLKS - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_NOTES - 1);

`ifdef MELODY_SEQ_ARTIC_GAP_EN
    localparam int unsigned      GAP_CLKS = ((BEAT_CLKS / 8) > 0) ? (BEAT_CLKS / 8) : 1;
    localparam int unsigned      GAP_W    = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CLKS - 1);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PLAY, S_GAP} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PLAY} state_t;
`endif

    state_t              state, state_d;
    logic [IDX_W-1:0]    idx, idx_d, nxt_idx;
    logic                played, played_d;
    logic                done_q, done_d;
    logic                load, end_mel, note_end;

    logic                key_s1, key_s2, key_prev, toggle;

    logic [PERIOD_W-1:0] tbl_p [NUM_NOTES];
    logic [DUR_W-1:0]    tbl_d [NUM_NOTES];
    logic [DUR_W-1:0]    rd_dur;

    logic [PERIOD_W-1:0] cur_period, tone_cnt;
    logic [DUR_W-1:0]    cur_dur, unit_cnt;
    logic [BEAT_W-1:0]   beat_cnt;
    logic                buzzer_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_s1   <= 1'b1;
            key_s2   <= 1'b1;
            key_prev <= 1'b1;
        end else begin
            key_s1   <= key;
            key_s2   <= key_s1;
            key_prev <= key_s2;
        end
    end

    assign toggle = key_prev & ~key_s2;

    // Table deliberately survives reset; only host writes change it.
    always_ff @(posedge clk) begin
        if (tbl_we) begin
            tbl_p[tbl_addr] <= tbl_period;
            tbl_d[tbl_addr] <= tbl_dur;
        end
    end

    assign rd_dur   = tbl_d[idx];
    assign nxt_idx  = idx + IDX_W'(1);
    assign note_end = (beat_cnt == BEAT_LAST) && (unit_cnt == cur_dur - DUR_W'(1));

`ifdef MELODY_SEQ_ARTIC_GAP_EN
    logic [GAP_W-1:0] gap_cnt;
    logic             gap_end;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            gap_cnt <= '0;
        else if (state == S_GAP && !gap_end)
            gap_cnt <= gap_cnt + GAP_W'(1);
        else
            gap_cnt <= '0;
    end

    assign gap_end = (gap_cnt == GAP_LAST);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            idx    <= '0;
            played <= 1'b0;
            done_q <= 1'b0;
        end else begin
            state  <= state_d;
            idx    <= idx_d;
            played <= played_d;
            done_q <= done_d;
        end
    end

    always_comb begin
        state_d  = state;
        idx_d    = idx;
        played_d = played;
        done_d   = 1'b0;
        load     = 1'b0;
        end_mel  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (toggle) begin
                    state_d  = S_FETCH;
                    idx_d    = '0;
                    played_d = 1'b0;
                end
            end
            S_FETCH: begin
                if (toggle) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end else if (rd_dur == '0) begin
                    end_mel = 1'b1;
                end else begin
                    load     = 1'b1;
                    played_d = 1'b1;
                    state_d  = S_PLAY;
                end
            end
            S_PLAY: begin
                if (toggle) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end else if (note_end) begin
                    if (idx == LAST_IDX) begin
                        end_mel = 1'b1;
                    end else begin
                        idx_d = nxt_idx;
`ifdef MELODY_SEQ_ARTIC_GAP_EN
                        // A following end marker skips the gap and ends straight from FETCH.
                        state_d = (tbl_d[nxt_idx] == '0) ? S_FETCH : S_GAP;
`else
                        state_d = S_FETCH;
`endif
                    end
                end
            end
`ifdef MELODY_SEQ_ARTIC_GAP_EN
            S_GAP: begin
                if (toggle) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end else if (gap_end) begin
                    state_d = S_FETCH;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
                idx_d   = '0;
            end
        endcase

        // Looping needs a note played this pass, so an empty table cannot spin in FETCH.
        if (end_mel) begin
            idx_d = '0;
            if (loop_en && played) begin
                state_d  = S_FETCH;
                played_d = 1'b0;
            end else begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_period <= '0;
            cur_dur    <= '0;
            tone_cnt   <= '0;
            beat_cnt   <= '0;
            unit_cnt   <= '0;
            buzzer_q   <= IDLE_LEVEL;
        end else if (load) begin
            cur_period <= tbl_p[idx];
            cur_dur    <= rd_dur;
            tone_cnt   <= '0;
            beat_cnt   <= '0;
            unit_cnt   <= '0;
            buzzer_q   <= IDLE_LEVEL;
        end else if (state == S_PLAY && state_d == S_PLAY) begin
            if (beat_cnt == BEAT_LAST) begin
                beat_cnt <= '0;
                unit_cnt <= unit_cnt + DUR_W'(1);
            end else begin
                beat_cnt <= beat_cnt + BEAT_W'(1);
            end
            if (cur_period != '0) begin
                if (tone_cnt == cur_period - PERIOD_W'(1)) begin
                    tone_cnt <= '0;
                    buzzer_q <= ~buzzer_q;
                end else begin
                    tone_cnt <= tone_cnt + PERIOD_W'(1);
                end
            end
        end else begin
            buzzer_q <= IDLE_LEVEL;
        end
    end

    assign buzzer_o   = buzzer_q;
    assign playing_o  = (state != S_IDLE);
    assign note_idx_o = idx;
    assign led_o      = playing_o ? 4'(idx) : 4'd0;
    assign done_o     = done_q;

endmodule

// File: tb/tb_melody_seq.sv
// Scoreboard bench for melody_seq: expected output-change events are queued by the
// stimulus and matched by a negedge monitor against cycle offset and output values.
module tb_melody_seq;

    localparam int unsigned NN = 4;
    localparam int unsigned PW = 8;
    localparam int unsigned DW = 4;
    localparam int unsigned BC = 10;
    localparam int unsigned IW = 2;

    logic          clk = 1'b0;
    logic          reset, key, loop_en, tbl_we;
    logic [IW-1:0] tbl_addr;
    logic [PW-1:0] tbl_period;
    logic [DW-1:0] tbl_dur;
    logic          buzzer_o, playing_o, done_o;
    logic [IW-1:0] note_idx_o;
    logic [3:0]    led_o;

    melody_seq #(
        .NUM_NOTES (NN),
        .PERIOD_W  (PW),
        .DUR_W     (DW),
        .BEAT_CLKS (BC),
        .IDLE_LEVEL(1'b1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .key       (key),
        .loop_en   (loop_en),
        .tbl_we    (tbl_we),
        .tbl_addr  (tbl_addr),
        .tbl_period(tbl_period),
        .tbl_dur   (tbl_dur),
        .buzzer_o  (buzzer_o),
        .playing_o (playing_o),
        .note_idx_o(note_idx_o),
        .led_o     (led_o),
        .done_o    (done_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            t;
        logic          buz;
        logic          play;
        logic [IW-1:0] idx;
        logic          done;
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  mark = 0;
    bit  mon_en = 1'b0;
    logic [IW+2:0] last_s = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [IW+2:0] cur;
        logic [3:0]    exp_led;
        ev_t           e;
        cur = {buzzer_o, playing_o, done_o, note_idx_o};
        if (mon_en && cur !== last_s) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event t=%0d: got buz=%b play=%b done=%b idx=%0d, required no change",
                         cyc - mark, buzzer_o, playing_o, done_o, note_idx_o);
            end else begin
                e = exp_q.pop_front();
                exp_led = e.play ? 4'(e.idx) : 4'd0;
                if ((cyc - mark) != e.t || buzzer_o !== e.buz || playing_o !== e.play ||
                    note_idx_o !== e.idx || done_o !== e.done || led_o !== exp_led) begin
                    errors++;
                    $display("FAIL event: got t=%0d buz=%b play=%b idx=%0d done=%b led=%0d, required t=%0d buz=%b play=%b idx=%0d done=%b led=%0d",
                             cyc - mark, buzzer_o, playing_o, note_idx_o, done_o, led_o,
                             e.t, e.buz, e.play, e.idx, e.done, exp_led);
                end
            end
        end
        last_s = cur;
    end

    task automatic ev(input int t, input logic b, input logic p, input int i, input logic d);
        ev_t e;
        e.t = t; e.buz = b; e.play = p; e.idx = IW'(i); e.done = d;
        exp_q.push_back(e);
    endtask

    task automatic go_cycles(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic wait_to(input int t);
        while (cyc < mark + t) begin @(posedge clk); #2; end
    endtask

    task automatic wr(input int a, input int p, input int d);
        tbl_we = 1'b1; tbl_addr = IW'(a); tbl_period = PW'(p); tbl_dur = DW'(d);
        go_cycles(1);
        tbl_we = 1'b0;
    endtask

    task automatic start();
        key = 1'b1;
        go_cycles(4);
        key = 1'b0;
        mark = cyc;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin go_cycles(1); n++; end
        go_cycles(6);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected events not seen, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    // Table A pass, f = cycle of FETCH of entry 0: {3,2},{0,1},{5,1},{7,0}
    task automatic pass_a(input int f);
        ev(f+4, 0, 1, 0, 0); ev(f+7, 1, 1, 0, 0); ev(f+10, 0, 1, 0, 0);
        ev(f+13, 1, 1, 0, 0); ev(f+16, 0, 1, 0, 0); ev(f+19, 1, 1, 0, 0);
        ev(f+21, 1, 1, 1, 0); ev(f+32, 1, 1, 2, 0);
        ev(f+38, 0, 1, 2, 0); ev(f+43, 1, 1, 3, 0);
    endtask

    // Table B pass: {4,1},{0,1},{0,1},{0,1}
    task automatic pass_b(input int f);
        ev(f+5, 0, 1, 0, 0); ev(f+9, 1, 1, 0, 0);
        ev(f+11, 1, 1, 1, 0); ev(f+22, 1, 1, 2, 0); ev(f+33, 1, 1, 3, 0);
    endtask

    task automatic load_a();
        wr(0, 3, 2); wr(1, 0, 1); wr(2, 5, 1); wr(3, 7, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 20000 cycles");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; key = 1'b1; loop_en = 1'b0; tbl_we = 1'b0;
        tbl_addr = '0; tbl_period = '0; tbl_dur = '0;
        go_cycles(3);
        chk("reset_buzzer", buzzer_o, 1);
        chk("reset_playing", playing_o, 0);
        chk("reset_idx", note_idx_o, 0);
        chk("reset_led", led_o, 0);
        chk("reset_done", done_o, 0);
        reset = 1'b0;
        go_cycles(2);
        mon_en = 1'b1;

        // Single pass ending on the end marker
        load_a();
        start();
        ev(3, 1, 1, 0, 0); pass_a(3); ev(47, 1, 0, 0, 1); ev(48, 1, 0, 0, 0);
        drain("single_pass");

        // Looping over three passes, then stop in the middle of entry 0
        loop_en = 1'b1;
        start();
        ev(3, 1, 1, 0, 0); pass_a(3);
        ev(47, 1, 1, 0, 0); pass_a(47);
        ev(91, 1, 1, 0, 0); pass_a(91);
        ev(135, 1, 1, 0, 0); ev(139, 0, 1, 0, 0); ev(142, 1, 1, 0, 0); ev(145, 0, 1, 0, 0);
        ev(147, 1, 0, 0, 0);
        wait_to(50); key = 1'b1;
        wait_to(144); key = 1'b0;
        drain("loop_then_stop");

        // Restart after the stop begins again at entry 0
        loop_en = 1'b0;
        start();
        ev(3, 1, 1, 0, 0); pass_a(3); ev(47, 1, 0, 0, 1); ev(48, 1, 0, 0, 0);
        drain("restart");

        // No end marker: index wrap ends the melody
        wr(0, 4, 1); wr(1, 0, 1); wr(2, 0, 1); wr(3, 0, 1);
        start();
        ev(3, 1, 1, 0, 0); pass_b(3); ev(47, 1, 0, 0, 1); ev(48, 1, 0, 0, 0);
        drain("wrap_done");

        // Wrap with looping, loop dropped during second pass
        loop_en = 1'b1;
        start();
        ev(3, 1, 1, 0, 0); pass_b(3); ev(47, 1, 1, 0, 0); pass_b(47);
        ev(91, 1, 0, 0, 1); ev(92, 1, 0, 0, 0);
        wait_to(20); key = 1'b1;
        wait_to(60); loop_en = 1'b0;
        drain("wrap_loop");

        // Empty melody with looping requested
        wr(0, 5, 0);
        loop_en = 1'b1;
        start();
        ev(3, 1, 1, 0, 0); ev(4, 1, 0, 0, 1); ev(5, 1, 0, 0, 0);
        go_cycles(20);
        drain("empty_melody");

        // Rewrite entry 0 while it plays; second pass uses {2,1}
        load_a();
        loop_en = 1'b1;
        start();
        ev(3, 1, 1, 0, 0); pass_a(3); ev(47, 1, 1, 0, 0);
        ev(50, 0, 1, 0, 0); ev(52, 1, 1, 0, 0); ev(54, 0, 1, 0, 0); ev(56, 1, 1, 0, 0);
        ev(58, 1, 1, 1, 0); ev(69, 1, 1, 2, 0); ev(75, 0, 1, 2, 0); ev(80, 1, 1, 3, 0);
        ev(81, 1, 0, 0, 1); ev(82, 1, 0, 0, 0);
        wait_to(10); wr(0, 2, 1);
        wait_to(15); key = 1'b1;
        wait_to(60); loop_en = 1'b0;
        drain("live_write");

        // Asynchronous reset in the middle of entry 2 (period 5, low phase)
        mon_en = 1'b0;
        start();
        wait_to(32);
        chk("pre_reset_buzzer", buzzer_o, 0);
        chk("pre_reset_idx", note_idx_o, 2);
        chk("pre_reset_led", led_o, 2);
        #1 reset = 1'b1;
        #1;
        chk("async_reset_buzzer", buzzer_o, 1);
        chk("async_reset_playing", playing_o, 0);
        chk("async_reset_idx", note_idx_o, 0);
        chk("async_reset_led", led_o, 0);
        chk("async_reset_done", done_o, 0);
        key = 1'b1;
        go_cycles(3);
        reset = 1'b0;
        go_cycles(6);
        chk("post_reset_playing", playing_o, 0);
        chk("post_reset_buzzer", buzzer_o, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/melody_seq.md
Name: melody_seq

Overview:
- Parametrised successor of the single-octave buzzer player.
- Plays a programmable melody from an internal note table. Each entry holds a half-period (clocks) and a duration (beat units).
- Start/stop is a debounced-edge toggle from a push key. Supports rests, end-of-melody markers, looping, and a run-time-writable table.
- Sits between board key/LED pins and the buzzer pin; the table is written by a host or a boot ROM loader.

Parameters:
- NUM_NOTES, 16, table depth (entries), power of two, >=2
- PERIOD_W, 20, width of half-period field (clocks); max tone period 2^PERIOD_W-1
- DUR_W, 4, width of duration field (beat units)
- BEAT_CLKS, 6_250_000, clocks per beat unit (50 MHz / 8)
- IDLE_LEVEL, 1'b1, buzzer_o level when silent (buzzer is active-low)
- IDX_W, $clog2(NUM_NOTES), table index width (derived)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- key  in  1  raw push key, asynchronous, active-low press
- loop_en  in  1  1 = restart from entry 0 at end of melody
- tbl_we  in  1  table write strobe
- tbl_addr  in  IDX_W  table write address
- tbl_period  in  PERIOD_W  half-period in clocks; 0 = rest
- tbl_dur  in  DUR_W  duration in beat units; 0 = end-of-melody marker
- buzzer_o  out  1  square-wave output
- playing_o  out  1  high while in FETCH/PLAY/GAP
- note_idx_o  out  IDX_W  index of the note currently sounding
- led_o  out  4  note_idx_o[3:0] while playing, 0 when idle
- done_o  out  1  one-cycle pulse when the melody ends without looping

Behaviour:
- Reset values: buzzer_o=IDLE_LEVEL; playing_o=0; note_idx_o=0; led_o=0; done_o=0; state=IDLE.
- Reset does not clear the table; table contents after configuration are undefined until written.
- Key handling: 2-FF synchroniser plus previous-sample register. A falling edge (prev=1, cur=0) generates a one-cycle toggle pulse.
- Table: synchronous write on tbl_we. A write to the entry being played does not affect that note, because fields are latched at FETCH. The write takes effect on the next fetch of that entry.
- States:
  - IDLE: buzzer_o=IDLE_LEVEL. On toggle, go to FETCH with idx=0.
  - FETCH (1 cycle): latch period/dur of table[idx].
    - If dur==0, end-of-melody handling applies.
    - Otherwise go to PLAY; clear the beat counter and tone counter; buzzer_o=IDLE_LEVEL on entry.
  - PLAY:
    - Tone counter increments each clock. At period-1 it clears and buzzer_o toggles, so the first toggle occurs `period` clocks after PLAY entry.
    - If period==0 (rest), buzzer_o is held at IDLE_LEVEL.
    - Beat counter runs dur*BEAT_CLKS clocks total. The PLAY dwell is exactly dur*BEAT_CLKS cycles.
    - Then idx+1, go to FETCH (or GAP if the optional feature is compiled in). buzzer_o returns to IDLE_LEVEL on exit.
- End-of-melody: triggered by dur==0 at FETCH, or by finishing entry NUM_NOTES-1 (idx wrap).
  - loop_en=1 and at least one note played this pass: idx=0, go to FETCH.
  - Otherwise: done_o pulses, go to IDLE.
  - Empty melody (entry 0 has dur==0) always goes to IDLE with done_o even if loop_en=1. This prevents an infinite FETCH loop.
- Toggle while in FETCH/PLAY/GAP: next cycle IDLE, buzzer_o=IDLE_LEVEL, idx=0, no done_o.
- Toggle coincident with end-of-melody: stop wins, no done_o.
- Arithmetic: beat counter width $clog2(BEAT_CLKS) plus DUR_W counters (unit counter, beat sub-counter). No multiplier. Counters never wrap mid-note.
- Asynchronous reset mid-note: immediate return to reset values; no glitch beyond reset assertion.

Optional Feature:
- Macro MELODY_SEQ_ARTIC_GAP_EN.
- Defined: after each non-final note, the block enters GAP for BEAT_CLKS/8 clocks with buzzer_o=IDLE_LEVEL, then goes to FETCH. A toggle in GAP stops as above. No GAP before end-of-melody handling.
- Undefined: the GAP state is absent; PLAY goes directly to FETCH, so consecutive notes are separated only by the 1 FETCH cycle.

Test Plan (BEAT_CLKS=10, NUM_NOTES=4, PERIOD_W=8, DUR_W=4, feature off unless noted):
- Reset, then write {period=3,dur=2},{0,1},{5,1},{x,0}; key falling edge -> playing_o=1 after 2 sync cycles; entry 0 toggles buzzer_o every 3 clocks for 20 clocks; entry 1 silent (IDLE_LEVEL) 10 clocks; entry 2 toggles every 5 for 10; then done_o 1-cycle pulse, IDLE, led_o=0.
- Same table, loop_en=1 -> after entry 2, note_idx_o returns to 0 and playing_o stays 1; no done_o over 3 passes.
- All 4 entries dur=1 (no marker) -> idx wraps after entry 3; done_o when loop_en=0, restart at 0 when loop_en=1.
- Second key edge mid entry 0 -> next cycle buzzer_o=IDLE_LEVEL, playing_o=0, no done_o; a later edge restarts from entry 0.
- Entry 0 dur=0, loop_en=1, start -> FETCH then IDLE with done_o pulse; no oscillation.
- Write entry 0 during its PLAY -> current note unchanged; next loop pass uses the new value. With MELODY_SEQ_ARTIC_GAP_EN, a 1-clock IDLE_LEVEL gap (10/8) appears between notes.
